game_flow_sm: RTL and testbench

//  Top-level game flow controller; sits above the player/enemy blocks.
//  - Sequences attract, play, death pause, wave-clear pause and game over.
//  - Owns lives, score, high score, wave number and enemies-remaining.
//  - Scores N enemy-hit channels per cycle.
//  - Publishes a coalesced HUD snapshot over a valid/ready handshake.

---
 rtl/game_flow_sm.sv | 204 ++++++++++++++++++++
 tb/tb_game_flow_sm.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_sm.sv
// rtl/game_flow_sm.sv - game flow controller: attract/play/pause/game-over sequencing, scoring, HUD snapshot
module game_flow_sm #(
    parameter int lives_p        = 3,
    parameter int score_width_p  = 16,
    parameter int enemies_p      = 55,
    parameter int hit_ports_p    = 2,
    parameter int points_p       = 10,
    parameter int pause_frames_p = 120,
    parameter int max_wave_p     = 15,
    localparam int lives_w       = $clog2(lives_p + 1),
    localparam int wave_w        = $clog2(max_wave_p + 1),
    localparam int enemies_w     = $clog2(enemies_p + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     frame_i,
    input  logic                     start_i,
    input  logic                     player_hit_i,
    input  logic [hit_ports_p-1:0]   enemy_hit_i,
    input  logic                     invaders_landed_i,
    output logic [2:0]               state_o,
    output logic                     play_en_o,
    output logic                     wave_reset_o,
    output logic [lives_w-1:0]       lives_o,
    output logic [score_width_p-1:0] score_o,
    output logic [score_width_p-1:0] high_score_o,
    output logic [wave_w-1:0]        wave_o,
    output logic [enemies_w-1:0]     enemies_left_o,
    output logic [score_width_p-1:0] hud_score_o,
    output logic [lives_w-1:0]       hud_lives_o,
    output logic [wave_w-1:0]        hud_wave_o,
    output logic                     valid_o,
    input  logic                     ready_i
);

    localparam int hit_cnt_w = $clog2(hit_ports_p + 1);
    localparam int pause_w   = $clog2(pause_frames_p + 1);
    localparam int sum_w     = score_width_p + 32;

    typedef enum logic [2:0] {
        ATTRACT    = 3'd0,
        PLAY       = 3'd1,
        DYING      = 3'd2,
        WAVE_CLEAR = 3'd3,
        GAME_OVER  = 3'd4
    } state_t;

    state_t                   state;
    logic                     start_q;
    logic                     start_edge;
    logic [pause_w-1:0]       pause_cnt;
    logic                     pause_done;
    logic [hit_cnt_w-1:0]     hit_cnt;
    logic [enemies_w-1:0]     kills;
    logic [sum_w-1:0]         score_sum;
    logic [score_width_p-1:0] score_nx;
    logic [lives_w-1:0]       lives_nx;
    logic [wave_w-1:0]        wave_nx;
    logic                     change;
    logic                     pending;

    assign state_o   = state;
    assign play_en_o = (state == PLAY);

    // Next values of the HUD-visible counters; shared by the FSM and the snapshot logic.
    always_comb begin
        start_edge = start_i & ~start_q;
        pause_done = (pause_cnt == pause_w'(pause_frames_p));
        hit_cnt    = '0;
        for (int i = 0; i < hit_ports_p; i++) begin
            hit_cnt = hit_cnt + hit_cnt_w'(enemy_hit_i[i]);
        end
        if (32'(hit_cnt) > 32'(enemies_left_o)) begin
            kills = enemies_left_o;
        end else begin
            kills = enemies_w'(hit_cnt);
        end
        score_sum = sum_w'(score_o) + sum_w'(kills) * sum_w'(points_p);
        score_nx  = score_o;
        lives_nx  = lives_o;
        wave_nx   = wave_o;
        case (state)
            ATTRACT: begin
                if (start_edge) begin
                    score_nx = '0;
                    lives_nx = lives_w'(lives_p);
                    wave_nx  = wave_w'(1);
                end
            end
            PLAY: begin
                if (score_sum > sum_w'({score_width_p{1'b1}})) begin
                    score_nx = {score_width_p{1'b1}};
                end else begin
                    score_nx = score_sum[score_width_p-1:0];
                end
                if (invaders_landed_i) begin
                    lives_nx = '0;
                end else if (player_hit_i && lives_o != '0) begin
                    lives_nx = lives_o - lives_w'(1);
                end
            end
            WAVE_CLEAR: begin
                if (pause_done && wave_o != wave_w'(max_wave_p)) begin
                    wave_nx = wave_o + wave_w'(1);
                end
            end
            default: ;
        endcase
        change = (score_nx != score_o) | (lives_nx != lives_o) | (wave_nx != wave_o);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state          <= ATTRACT;
            start_q        <= 1'b0;
            pause_cnt      <= '0;
            wave_reset_o   <= 1'b0;
            lives_o        <= '0;
            score_o        <= '0;
            high_score_o   <= '0;
            wave_o         <= '0;
            enemies_left_o <= '0;
        end else begin
            start_q      <= start_i;
            wave_reset_o <= 1'b0;
            score_o      <= score_nx;
            lives_o      <= lives_nx;
            wave_o       <= wave_nx;
            if (frame_i && !pause_done) begin
                pause_cnt <= pause_cnt + pause_w'(1);
            end
            case (state)
                ATTRACT: begin
                    if (start_edge) begin
                        state          <= PLAY;
                        enemies_left_o <= enemies_w'(enemies_p);
                        wave_reset_o   <= 1'b1;
                    end
                end
                PLAY: begin
                    enemies_left_o <= enemies_left_o - kills;
                    if (invaders_landed_i) begin
                        state        <= GAME_OVER;
                        pause_cnt    <= '0;
                        high_score_o <= (score_nx > high_score_o) ? score_nx : high_score_o;
                    end else if (player_hit_i) begin
                        state     <= DYING;
                        pause_cnt <= '0;
                    end else if (kills == enemies_left_o) begin
                        state     <= WAVE_CLEAR;
                        pause_cnt <= '0;
                    end
                end
                DYING: begin
                    if (pause_done) begin
                        if (lives_o == '0) begin
                            state        <= GAME_OVER;
                            pause_cnt    <= '0;
                            high_score_o <= (score_nx > high_score_o) ? score_nx : high_score_o;
                        end else begin
                            state <= PLAY;
                        end
                    end
                end
                WAVE_CLEAR: begin
                    if (pause_done) begin
                        state          <= PLAY;
                        enemies_left_o <= enemies_w'(enemies_p);
                        wave_reset_o   <= 1'b1;
                    end
                end
                GAME_OVER: begin
                    if (pause_done && start_edge) begin
                        state <= ATTRACT;
                    end
                end
                default: state <= ATTRACT;
            endcase
        end
    end

    // Snapshot stays frozen while offered; changes seen meanwhile coalesce into pending.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_o     <= 1'b0;
            pending     <= 1'b0;
            hud_score_o <= '0;
            hud_lives_o <= '0;
            hud_wave_o  <= '0;
        end else if (valid_o) begin
            pending <= pending | change;
            if (ready_i) begin
                valid_o <= 1'b0;
            end
        end else if (pending || change) begin
            valid_o     <= 1'b1;
            pending     <= 1'b0;
            hud_score_o <= score_nx;
            hud_lives_o <= lives_nx;
            hud_wave_o  <= wave_nx;
        end
    end

endmodule

// File: tb/tb_game_flow_sm.sv
// tb/tb_game_flow_sm.sv - randomized and directed bench for game_flow_sm against a behavioural model
module tb_game_flow_sm;

    localparam int PF   = 120;
    localparam int MAXS = 65535;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        frame_i = 1'b0;
    logic        start_i = 1'b0;
    logic        player_hit_i = 1'b0;
    logic [1:0]  enemy_hit_i = 2'b00;
    logic        invaders_landed_i = 1'b0;
    logic        ready_i = 1'b0;
    logic [2:0]  state_o;
    logic        play_en_o;
    logic        wave_reset_o;
    logic [1:0]  lives_o;
    logic [15:0] score_o;
    logic [15:0] high_score_o;
    logic [3:0]  wave_o;
    logic [5:0]  enemies_left_o;
    logic [15:0] hud_score_o;
    logic [1:0]  hud_lives_o;
    logic [3:0]  hud_wave_o;
    logic        valid_o;

    int checks = 0;
    int failures = 0;

    int m_st, m_lives, m_score, m_hs, m_wave, m_left, m_pc;
    bit m_sq, m_wr, m_v, m_p;
    int m_hud_s, m_hud_l, m_hud_w;

    game_flow_sm dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .frame_i(frame_i), .start_i(start_i),
        .player_hit_i(player_hit_i), .enemy_hit_i(enemy_hit_i),
        .invaders_landed_i(invaders_landed_i), .state_o(state_o), .play_en_o(play_en_o),
        .wave_reset_o(wave_reset_o), .lives_o(lives_o), .score_o(score_o),
        .high_score_o(high_score_o), .wave_o(wave_o), .enemies_left_o(enemies_left_o),
        .hud_score_o(hud_score_o), .hud_lives_o(hud_lives_o), .hud_wave_o(hud_wave_o),
        .valid_o(valid_o), .ready_i(ready_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_st = 0; m_lives = 0; m_score = 0; m_hs = 0; m_wave = 0; m_left = 0; m_pc = 0;
        m_sq = 0; m_wr = 0; m_v = 0; m_p = 0; m_hud_s = 0; m_hud_l = 0; m_hud_w = 0;
    endfunction

    function automatic void go_over();
        m_st = 4;
        m_pc = 0;
        if (m_score > m_hs) m_hs = m_score;
    endfunction

    function automatic void model_step();
        int k, os, ol, ow;
        bit se, chg;
        os = m_score; ol = m_lives; ow = m_wave;
        se = start_i && !m_sq;
        m_sq = start_i;
        m_wr = 0;
        case (m_st)
            0: if (se) begin
                m_st = 1; m_lives = 3; m_score = 0; m_wave = 1; m_left = 55; m_wr = 1;
            end
            1: begin
                k = $countones(enemy_hit_i);
                if (k > m_left) k = m_left;
                m_left -= k;
                m_score = (m_score + 10 * k > MAXS) ? MAXS : m_score + 10 * k;
                if (invaders_landed_i) begin
                    m_lives = 0;
                    go_over();
                end else if (player_hit_i) begin
                    if (m_lives > 0) m_lives--;
                    m_st = 2; m_pc = 0;
                end else if (m_left == 0) begin
                    m_st = 3; m_pc = 0;
                end
            end
            2: if (m_pc == PF) begin
                if (m_lives == 0) go_over(); else m_st = 1;
            end else if (frame_i) m_pc++;
            3: if (m_pc == PF) begin
                m_st = 1; m_wave = (m_wave < 15) ? m_wave + 1 : 15; m_left = 55; m_wr = 1;
            end else if (frame_i) m_pc++;
            default: if (m_pc == PF) begin
                if (se) m_st = 0;
            end else if (frame_i) m_pc++;
        endcase
        chg = (os != m_score) || (ol != m_lives) || (ow != m_wave);
        if (m_v) begin
            m_p = m_p | chg;
            if (ready_i) m_v = 0;
        end else if (m_p || chg) begin
            m_v = 1; m_p = 0; m_hud_s = m_score; m_hud_l = m_lives; m_hud_w = m_wave;
        end
    endfunction

    task automatic compare_all();
        check("state", 32'(state_o), m_st);
        check("lives", 32'(lives_o), m_lives);
        check("score", 32'(score_o), m_score);
        check("high_score", 32'(high_score_o), m_hs);
        check("wave", 32'(wave_o), m_wave);
        check("enemies_left", 32'(enemies_left_o), m_left);
        check("wave_reset", 32'(wave_reset_o), 32'(m_wr));
        check("play_en", 32'(play_en_o), (m_st == 1) ? 1 : 0);
        check("valid", 32'(valid_o), 32'(m_v));
        check("hud_score", 32'(hud_score_o), m_hud_s);
        check("hud_lives", 32'(hud_lives_o), m_hud_l);
        check("hud_wave", 32'(hud_wave_o), m_hud_w);
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
        compare_all();
    endtask

    task automatic clear_inputs();
        frame_i = 0; player_hit_i = 0; enemy_hit_i = 2'b00; invaders_landed_i = 0;
    endtask

    // Async reset is applied between clock edges and observed before any edge arrives.
    task automatic async_reset(input string tag);
        #2;
        reset_ni = 0;
        #1;
        check({tag, "_state"}, 32'(state_o), 0);
        check({tag, "_score"}, 32'(score_o), 0);
        check({tag, "_high"}, 32'(high_score_o), 0);
        check({tag, "_lives"}, 32'(lives_o), 0);
        check({tag, "_wave"}, 32'(wave_o), 0);
        check({tag, "_left"}, 32'(enemies_left_o), 0);
        check({tag, "_valid"}, 32'(valid_o), 0);
        check({tag, "_hud"}, 32'({hud_score_o, hud_lives_o, hud_wave_o}), 0);
        check({tag, "_outs"}, 32'({play_en_o, wave_reset_o}), 0);
        model_reset();
        start_i = 0;
        clear_inputs();
        @(posedge clk_i);
        @(negedge clk_i);
        reset_ni = 1;
    endtask

    initial begin
        int n, wr_seen;
        model_reset();
        ready_i = 1;
        repeat (2) @(negedge clk_i);
        compare_all();
        reset_ni = 1;
        tick();

        // start edge enters PLAY with a fresh game
        start_i = 1;
        tick();
        check("t1_state", 32'(state_o), 1);
        check("t1_lives", 32'(lives_o), 3);
        check("t1_left", 32'(enemies_left_o), 55);
        check("t1_wave_reset", 32'(wave_reset_o), 1);
        check("t1_hud_lives", 32'({valid_o, hud_lives_o}), 32'({1'b1, 2'd3}));
        tick();
        check("t1_wave_reset_end", 32'(wave_reset_o), 0);

        // two hits at once, then a coalesced hit while the consumer stalls
        enemy_hit_i = 2'b11;
        tick();
        check("t2_score", 32'(score_o), 20);
        check("t2_left", 32'(enemies_left_o), 53);
        ready_i = 0; enemy_hit_i = 2'b01;
        tick();
        check("t2_hud_frozen", 32'(hud_score_o), 20);
        enemy_hit_i = 2'b00;
        tick();
        check("t2_hud_frozen2", 32'(hud_score_o), 20);
        ready_i = 1;
        tick();
        tick();
        check("t2_hud_follow", 32'({valid_o, hud_score_o}), 32'({1'b1, 16'd30}));

        // last enemy with two hits: only one is scored
        while (m_left > 2) begin enemy_hit_i = 2'b11; tick(); end
        enemy_hit_i = 2'b01; tick();
        check("t3_left_one", 32'(enemies_left_o), 1);
        enemy_hit_i = 2'b11; tick();
        check("t3_score", 32'(score_o), 550);
        check("t3_state", 32'(state_o), 3);
        clear_inputs(); frame_i = 1;
        n = 0; wr_seen = 0;
        while (state_o == 3 && n < 300) begin tick(); n++; wr_seen += wave_reset_o; end
        check("t3_pause_len", n, 121);
        check("t3_wave_reset_cnt", wr_seen, 1);
        check("t3_wave_left", 32'({wave_o, enemies_left_o}), 32'({4'd2, 6'd55}));

        // player hit and enemy hit in the same cycle
        player_hit_i = 1; enemy_hit_i = 2'b01; tick();
        check("t4_lives", 32'(lives_o), 2);
        check("t4_score", 32'(score_o), 560);
        check("t4_state", 32'(state_o), 2);
        clear_inputs(); frame_i = 1;
        n = 0; wr_seen = 0;
        while (state_o == 2 && n < 300) begin tick(); n++; wr_seen += wave_reset_o; end
        check("t4_pause_len", n, 121);
        check("t4_wave_reset_cnt", wr_seen, 0);
        check("t4_state_back", 32'(state_o), 1);

        // landing wins over player hit; early start edge is ignored
        invaders_landed_i = 1; player_hit_i = 1; tick();
        check("t5_lives", 32'(lives_o), 0);
        check("t5_state", 32'(state_o), 4);
        check("t5_high", 32'(high_score_o), 560);
        clear_inputs(); frame_i = 1; start_i = 0;
        repeat (119) tick();
        start_i = 1; tick();
        check("t5_early_start", 32'(state_o), 4);
        start_i = 0; tick();
        start_i = 1; tick();
        check("t5_late_start", 32'(state_o), 0);
        check("t5_hold_score", 32'(score_o), 560);

        // randomized play
        for (int i = 0; i < 4000; i++) begin
            frame_i = ($urandom % 3) != 0;
            start_i = ($urandom % 4) == 0;
            player_hit_i = ($urandom % 40) == 0;
            invaders_landed_i = ($urandom % 150) == 0;
            enemy_hit_i = 2'($urandom);
            ready_i = $urandom % 2;
            tick();
        end
        clear_inputs(); start_i = 0; ready_i = 1;
        repeat (4) tick();
        check("drain_hud", 32'({hud_score_o, hud_lives_o, hud_wave_o}),
              32'({16'(m_score), 2'(m_lives), 4'(m_wave)}));

        async_reset("rst_rand");
        tick();

        // long game to reach score saturation and the wave ceiling
        start_i = 1; frame_i = 1; ready_i = 1; tick();
        n = 0;
        while (m_score < 65530 && n < 40000) begin
            enemy_hit_i = (m_st != 1) ? 2'b00 : ((65530 - m_score >= 20) ? 2'b11 : 2'b01);
            tick(); n++;
        end
        check("grind_reach", 32'(score_o), 65530);
        enemy_hit_i = 2'b00;
        n = 0;
        while (m_st != 1 && n < 300) begin tick(); n++; end
        enemy_hit_i = 2'b01; tick();
        check("sat_score", 32'(score_o), 32'hFFFF);
        enemy_hit_i = 2'b11; tick();
        check("sat_hold", 32'(score_o), 32'hFFFF);
        check("wave_ceiling", 32'(wave_o), 15);
        n = 0;
        while (m_st == 1 && n < 100) begin tick(); n++; end
        check("t6_in_wave_clear", 32'(state_o), 3);
        enemy_hit_i = 2'b00;
        repeat (5) tick();
        async_reset("rst_wc");
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
